// File: rtl/ir_nec_pkg.sv
// Shared FSM states, timing windows (us) and register map for the NEC IR decoder.
package ir_nec_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD_LOW,
      S_LEAD_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_DATA_STOP,
      S_REPEAT_STOP
   } state_e;

   localparam int W_W = 16;

   localparam logic [W_W-1:0] LEAD_LOW_MIN      = 16'd8000;
   localparam logic [W_W-1:0] LEAD_LOW_MAX      = 16'd10000;
   localparam logic [W_W-1:0] LEAD_HIGH_DATA_MIN = 16'd4000;
   localparam logic [W_W-1:0] LEAD_HIGH_DATA_MAX = 16'd5000;
   localparam logic [W_W-1:0] LEAD_HIGH_REP_MIN  = 16'd2000;
   localparam logic [W_W-1:0] LEAD_HIGH_REP_MAX  = 16'd2500;
   localparam logic [W_W-1:0] BIT_MIN           = 16'd400;
   localparam logic [W_W-1:0] BIT_MAX           = 16'd700;
   localparam logic [W_W-1:0] ONE_MIN           = 16'd1400;
   localparam logic [W_W-1:0] ONE_MAX           = 16'd1900;

   localparam logic ADDR_CODE   = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   localparam int ST_NEW     = 0;
   localparam int ST_REP     = 1;
   localparam int ST_ERR     = 2;
   localparam int ST_CNT_LSB = 8;

   function automatic logic in_win(input logic [W_W-1:0] w,
                                   input logic [W_W-1:0] lo,
                                   input logic [W_W-1:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes the IR pin, detects edges and measures the time in us since the last edge.
// Below 1 MHz the counter advances several us per clock so slow clocks keep us units.
module ir_pulse_timer
   import ir_nec_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TIMEOUT_US = 12000
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           ir_i,
   output logic           rise_o,
   output logic           fall_o,
   output logic [W_W-1:0] width_us_o
);

   localparam int US_STEP = (CLK_HZ >= 1000000) ? 1 : (1000000 / CLK_HZ);
   localparam int W1      = W_W + 1;
   localparam logic [W_W:0] STEP  = W1'(US_STEP);
   localparam logic [W_W:0] LIMIT = W1'(TIMEOUT_US);

   // [0],[1]: synchronizer, [2]: previous synchronized level; idle level is high
   logic [2:0] sync_q;
   logic       tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 3'b111;
      else          sync_q <= {sync_q[1:0], ir_i};
   end

   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

   generate
      if (CLK_HZ >= 2000000) begin : g_div
         localparam int DIV = CLK_HZ / 1000000;
         localparam int DW  = $clog2(DIV);
         localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
         logic [DW-1:0] div_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)              div_q <= '0;
            else if (div_q == DIV_LAST) div_q <= '0;
            else                       div_q <= div_q + DW'(1);
         end
         assign tick = (div_q == DIV_LAST);
      end else begin : g_fast
         assign tick = 1'b1;
      end
   endgenerate

   logic [W_W-1:0] width_q, width_d;
   logic [W_W:0]   sum;

   always_comb begin
      sum     = {1'b0, width_q} + STEP;
      width_d = width_q;
      if (rise_o || fall_o) width_d = '0;
      else if (tick)        width_d = (sum >= LIMIT) ? LIMIT[W_W-1:0] : sum[W_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) width_q <= '0;
      else          width_q <= width_d;
   end

   assign width_us_o = width_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder with an Avalon-MM code/status register pair.
// Optional IR_CHECK_EN: reject data frames whose address/command complements do not match.
module ir_nec_decoder
   import ir_nec_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TIMEOUT_US = 12000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        iIR,
   input  logic        avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        Get_Flag_o
);

   localparam logic [W_W-1:0] TMO = W_W'(TIMEOUT_US);

   logic           rise, fall;
   logic [W_W-1:0] width;

   ir_pulse_timer #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .ir_i       (iIR),
      .rise_o     (rise),
      .fall_o     (fall),
      .width_us_o (width)
   );

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] shift_q, shift_d;
   logic        commit_frame, commit_rep, err_evt, frame_ok;

`ifdef IR_CHECK_EN
   assign frame_ok = (shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]);
`else
   assign frame_ok = 1'b1;
`endif

   logic        have_frame_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      commit_frame = 1'b0;
      commit_rep   = 1'b0;
      err_evt      = 1'b0;
      unique case (state_q)
         S_IDLE: if (fall) state_d = S_LEAD_LOW;
         S_LEAD_LOW: if (rise) begin
            if (in_win(width, LEAD_LOW_MIN, LEAD_LOW_MAX)) state_d = S_LEAD_HIGH;
            else begin state_d = S_IDLE; err_evt = 1'b1; end
         end
         S_LEAD_HIGH: if (fall) begin
            if (in_win(width, LEAD_HIGH_DATA_MIN, LEAD_HIGH_DATA_MAX)) begin
               state_d = S_BIT_LOW;
               idx_d   = '0;
            end else if (in_win(width, LEAD_HIGH_REP_MIN, LEAD_HIGH_REP_MAX)) begin
               state_d = S_REPEAT_STOP;
            end else begin
               state_d = S_IDLE;
               err_evt = 1'b1;
            end
         end
         S_BIT_LOW: if (rise) begin
            if (in_win(width, BIT_MIN, BIT_MAX)) state_d = S_BIT_HIGH;
            else begin state_d = S_IDLE; err_evt = 1'b1; end
         end
         S_BIT_HIGH: if (fall) begin
            if (in_win(width, BIT_MIN, BIT_MAX) || in_win(width, ONE_MIN, ONE_MAX)) begin
               // LSB first: after 32 right shifts the first bit lands in bit 0
               shift_d = {in_win(width, ONE_MIN, ONE_MAX), shift_q[31:1]};
               if (idx_q == 5'd31) state_d = S_DATA_STOP;
               else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_BIT_LOW;
               end
            end else begin
               state_d = S_IDLE;
               err_evt = 1'b1;
            end
         end
         S_DATA_STOP: if (rise) begin
            state_d = S_IDLE;
            if (in_win(width, BIT_MIN, BIT_MAX) && frame_ok) commit_frame = 1'b1;
            else err_evt = 1'b1;
         end
         S_REPEAT_STOP: if (rise) begin
            state_d = S_IDLE;
            if (in_win(width, BIT_MIN, BIT_MAX)) commit_rep = have_frame_q;
            else err_evt = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && !rise && !fall && width >= TMO) begin
         state_d = S_IDLE;
         err_evt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   logic [31:0] code_q, rdata_q, status;
   logic        new_q, rep_q, err_q, new_d, rep_d, err_d, clr;
   logic [7:0]  cnt_q, cnt_d;
   logic        unused_wdata;

   assign unused_wdata = ^avs_writedata[31:1];
   assign clr = avs_write && (avs_address == ADDR_STATUS) && avs_writedata[0];

   // A clear in the same cycle as a commit loses to the commit
   always_comb begin
      new_d = new_q;
      rep_d = rep_q;
      err_d = err_q;
      cnt_d = cnt_q;
      if (clr) begin
         new_d = 1'b0;
         rep_d = 1'b0;
         err_d = 1'b0;
         cnt_d = '0;
      end
      if (err_evt) err_d = 1'b1;
      if (commit_frame) begin
         new_d = 1'b1;
         rep_d = rep_q;
         cnt_d = '0;
      end
      if (commit_rep) begin
         new_d = new_q;
         rep_d = 1'b1;
         if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
      end
   end

   always_comb begin
      status                      = '0;
      status[ST_NEW]              = new_q;
      status[ST_REP]              = rep_q;
      status[ST_ERR]              = err_q;
      status[ST_CNT_LSB +: 8]     = cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         code_q       <= '0;
         new_q        <= 1'b0;
         rep_q        <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         have_frame_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         new_q <= new_d;
         rep_q <= rep_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
         if (commit_frame) begin
            code_q       <= shift_q;
            have_frame_q <= 1'b1;
         end
         if (avs_read) rdata_q <= (avs_address == ADDR_STATUS) ? status : code_q;
      end
   end

   assign avs_readdata = rdata_q;
   assign Get_Flag_o   = new_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench: each clock stands for 100 us (CLK_HZ=10000), so a segment of N clocks measures (N-1)*100 us.
module tb_ir_nec_decoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        iIR;
   logic        avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        Get_Flag_o;

   int total_cnt = 0;
   int fail_cnt  = 0;

   ir_nec_decoder #(.CLK_HZ(10000), .TIMEOUT_US(12000)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .iIR           (iIR),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .Get_Flag_o    (Get_Flag_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] code;
      int          lead_n;
      int          low_n;
      logic        exp_flag;
      logic [31:0] exp_code;
      logic [31:0] exp_status;
   } vec_t;

   vec_t vec [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got=%08h want=%08h", name, act, exp);
      end else begin
         $display("ok   %s: %08h", name, act);
      end
   endtask

   task automatic seg(input logic lvl, input int n);
      iIR = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic addr, output logic [31:0] data);
      avs_address = addr;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      data        = avs_readdata;
   endtask

   task automatic wr(input logic addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   // Final rising edge; flag sampled one cycle before and at the commit cycle
   task automatic finish_frame(input bit clr, output logic early, output logic late);
      iIR = 1'b1;
      @(negedge clk);
      @(negedge clk);
      early = Get_Flag_o;
      if (clr) begin
         avs_address   = 1'b1;
         avs_writedata = 32'h1;
         avs_write     = 1'b1;
      end
      @(negedge clk);
      avs_write = 1'b0;
      late      = Get_Flag_o;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] code, input int lead_n, input int low_n,
                             input bit clr, output logic early, output logic late);
      seg(1'b0, lead_n);
      seg(1'b1, 46);
      for (int i = 0; i < 32; i++) begin
         seg(1'b0, low_n);
         seg(1'b1, code[i] ? 18 : 7);
      end
      seg(1'b0, 7);
      finish_frame(clr, early, late);
   endtask

   task automatic send_repeat(input bit clr, output logic early, output logic late);
      seg(1'b0, 91);
      seg(1'b1, 24);
      seg(1'b0, 7);
      finish_frame(clr, early, late);
   endtask

   logic [31:0] d;
   logic        fe, fl;

   initial begin
      reset_n = 1'b0; iIR = 1'b1; avs_address = 1'b0; avs_read = 1'b0;
      avs_write = 1'b0; avs_writedata = '0;

      vec[0] = '{32'hBA45FF00,  91, 7, 1'b1, 32'hBA45FF00, 32'h1};
      vec[1] = '{32'hE718FF00,  81, 8, 1'b1, 32'hE718FF00, 32'h1};
      vec[2] = '{32'h7F80BF40, 101, 5, 1'b1, 32'h7F80BF40, 32'h1};
      vec[3] = '{32'h12345678,  91, 9, 1'b0, 32'h7F80BF40, 32'h4};
`ifdef IR_CHECK_EN
      vec[4] = '{32'h00000000,  91, 7, 1'b0, 32'h7F80BF40, 32'h4};
`else
      vec[4] = '{32'h00000000,  91, 7, 1'b1, 32'h00000000, 32'h1};
`endif

      repeat (3) @(negedge clk);
      chk("reset_flag", {31'b0, Get_Flag_o}, 32'h0);
      chk("reset_rdata", avs_readdata, 32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      rd(1'b0, d); chk("reset_code", d, 32'h0);
      rd(1'b1, d); chk("reset_status", d, 32'h0);

      for (int v = 0; v < 5; v++) begin
         send_frame(vec[v].code, vec[v].lead_n, vec[v].low_n, 1'b0, fe, fl);
         chk($sformatf("v%0d_flag_pre", v), {31'b0, fe}, 32'h0);
         chk($sformatf("v%0d_flag", v), {31'b0, fl}, {31'b0, vec[v].exp_flag});
         rd(1'b0, d); chk($sformatf("v%0d_code", v), d, vec[v].exp_code);
         rd(1'b1, d); chk($sformatf("v%0d_status", v), d, vec[v].exp_status);
         wr(1'b1, 32'h1);
         rd(1'b1, d); chk($sformatf("v%0d_cleared", v), d, 32'h0);
         chk($sformatf("v%0d_flag_clr", v), {31'b0, Get_Flag_o}, 32'h0);
      end

      // Reset in the middle of a frame, then a repeat with no frame since reset
      seg(1'b0, 91); seg(1'b1, 46);
      for (int i = 0; i < 5; i++) begin seg(1'b0, 7); seg(1'b1, 18); end
      seg(1'b0, 7);
      reset_n = 1'b0;
      iIR     = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      rd(1'b0, d); chk("midrst_code", d, 32'h0);
      rd(1'b1, d); chk("midrst_status", d, 32'h0);
      send_repeat(1'b0, fe, fl);
      chk("orphan_rep_flag", {31'b0, fl}, 32'h0);
      rd(1'b1, d); chk("orphan_rep_status", d, 32'h0);

      // Frame plus three repeats, 110 ms apart
      send_frame(32'hBA45FF00, 91, 7, 1'b0, fe, fl);
      chk("rep_frame_flag", {31'b0, fl}, 32'h1);
      repeat (400) @(negedge clk);
      for (int r = 0; r < 3; r++) begin
         send_repeat(1'b0, fe, fl);
         rd(1'b1, d); chk($sformatf("rep%0d_status", r), d, 32'((r + 1) << 8) | 32'h3);
         repeat (960) @(negedge clk);
      end
      rd(1'b0, d); chk("rep_code", d, 32'hBA45FF00);

      // Short leader
      wr(1'b1, 32'h1);
      seg(1'b0, 71);
      iIR = 1'b1;
      repeat (20) @(negedge clk);
      chk("short_lead_flag", {31'b0, Get_Flag_o}, 32'h0);
      rd(1'b1, d); chk("short_lead_status", d, 32'h4);

      // Line stuck low after 10 bits
      wr(1'b1, 32'h1);
      seg(1'b0, 91); seg(1'b1, 46);
      for (int i = 0; i < 10; i++) begin seg(1'b0, 7); seg(1'b1, 7); end
      iIR = 1'b0;
      repeat (95) @(negedge clk);
      rd(1'b1, d); chk("tmo_before", d, 32'h0);
      repeat (40) @(negedge clk);
      rd(1'b1, d); chk("tmo_after", d, 32'h4);
      iIR = 1'b1;
      repeat (20) @(negedge clk);
      send_frame(32'hE718FF00, 91, 7, 1'b0, fe, fl);
      chk("tmo_next_flag", {31'b0, fl}, 32'h1);
      rd(1'b0, d); chk("tmo_next_code", d, 32'hE718FF00);
      rd(1'b1, d); chk("tmo_next_status", d, 32'h5);

      // Clear colliding with a frame commit, then with a repeat commit
      wr(1'b1, 32'h1);
      send_frame(32'hBA45FF00, 91, 7, 1'b1, fe, fl);
      chk("clr_frame_pre", {31'b0, fe}, 32'h0);
      chk("clr_frame_flag", {31'b0, fl}, 32'h1);
      rd(1'b1, d); chk("clr_frame_status", d, 32'h1);
      send_repeat(1'b0, fe, fl);
      send_repeat(1'b0, fe, fl);
      rd(1'b1, d); chk("clr_rep_before", d, 32'h203);
      send_repeat(1'b1, fe, fl);
      chk("clr_rep_flag", {31'b0, fl}, 32'h1);
      rd(1'b1, d); chk("clr_rep_status", d, 32'h103);
      wr(1'b0, 32'h1);
      rd(1'b1, d); chk("wr_addr0_ignored", d, 32'h103);

      $display("test done: total=%0d bad=%0d", total_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
- Decodes NEC-protocol frames from the demodulated IR receiver pin (iIR, active-low bursts) into a 32-bit key code.
- Sits upstream of the Nios II software as a Platform Designer IP: the conduit carries iIR in and Get_Flag_o out, and an Avalon-MM slave carries code and status to the CPU.
- Handles data frames, repeat frames, timing tolerance and timeouts.

Parameters:
- CLK_HZ, 50000000, system clock frequency; derives the 1 us tick divisor CLK_HZ/1000000.
- TIMEOUT_US, 12000, maximum width of any segment before the FSM aborts to IDLE.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- iIR  in  1  raw IR receiver output, idle high, asynchronous
- avs_address  in  1  0 = code, 1 = status
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data, read latency 1
- Get_Flag_o  out  1  level, high while an unread new frame exists

Behaviour:
- Single clock, clk. Reset is reset_n, asynchronous assert, active-low.
- Reset values: all outputs 0, code register 0, status 0, FSM in IDLE.
- Input path: iIR passes through a 2-flop synchronizer followed by an edge detector.
- Timing: a 1 us tick is produced from CLK_HZ. The width counter counts us since the last edge, clears on every edge and saturates at TIMEOUT_US.
- Segment widths are evaluated at the edge that ends each segment.
- FSM transitions:
  - IDLE -> LEAD_LOW on a falling edge.
  - LEAD_LOW: on rising edge, width 8000..10000 -> LEAD_HIGH; otherwise IDLE with err set.
  - LEAD_HIGH: on falling edge:
    - width 4000..5000 -> BIT_LOW, bit index cleared.
    - width 2000..2500 -> REPEAT_STOP.
    - otherwise IDLE with err set.
  - BIT_LOW: on rising edge, width 400..700 -> BIT_HIGH; otherwise IDLE with err set.
  - BIT_HIGH: on falling edge:
    - width 400..700 shifts in 0; width 1400..1900 shifts in 1; otherwise IDLE with err set.
    - After a valid bit: index 31 -> DATA_STOP, else BIT_LOW.
  - DATA_STOP: on rising edge, width 400..700 -> commit frame, IDLE; otherwise IDLE with err set.
  - REPEAT_STOP: on rising edge, width 400..700 -> commit repeat, IDLE; otherwise IDLE with err set.
- Bit order: LSB first, first bit -> code[0]. Layout is code[7:0]=addr, [15:8]=~addr, [23:16]=cmd, [31:24]=~cmd.
- Timeout: any non-IDLE state whose width counter reaches TIMEOUT_US -> IDLE with err set. IDLE ignores timeout.
- Frame commit (1 cycle after the stop edge):
  - Code register loaded from the shift register; new flag set; repeat count cleared.
  - The shift register is never visible partially filled.
- Repeat commit:
  - Only when a data frame has been committed since reset; otherwise ignored.
  - Repeat count incremented, saturating at 255; rep flag set.
- Status word layout: bit0 new, bit1 rep, bit2 err (sticky), bits15:8 repeat count, others 0.
- Reads:
  - Registered; avs_readdata is valid the cycle after avs_read and holds until the next read.
  - Reading does not clear anything.
- Writes: a write to address 1 with writedata bit0=1 clears new, rep, err and count. Writes to address 0 are ignored.
- Simultaneous clear write and commit in the same cycle: the commit wins; new/rep remain set, count = 1 for a repeat.
- Get_Flag_o equals the new flag.
- Reset mid-frame: abort immediately; the partial code is discarded.

Optional Feature:
- Macro: IR_CHECK_EN.
- Defined: a data frame commits only if code[15:8]==~code[7:0] and code[31:24]==~code[23:16]. On mismatch, err is set, nothing commits, FSM returns to IDLE.
- Undefined: no complement check, so extended-NEC 16-bit addresses are accepted.

Decomposition:
- Package ir_nec_pkg:
  - FSM state enum.
  - Timing window constants (LEAD_LOW_MIN/MAX, LEAD_HIGH_DATA_MIN/MAX, LEAD_HIGH_REP_MIN/MAX, BIT_MIN/MAX, ONE_MIN/MAX).
  - Register address constants and status bit indices.
- Sub-module ir_pulse_timer: synchronizer, edge detect, us tick, saturating width counter. Outputs rise, fall, width_us.

Test Plan:
- Valid frame for addr 0x00, cmd 0x45 -> Get_Flag_o high 1 cycle after stop edge; read addr 0 returns 0xBA45FF00; status = 0x00000001.
- Frame followed by 3 repeat frames, 110 ms apart -> status bits15:8 = 3, bit1 = 1; code unchanged.
- Leader low of 7000 us -> no commit; status bit2 = 1; Get_Flag_o stays 0.
- iIR held low after 10 bits -> abort at 12000 us; err set; next valid frame decodes correctly.
- Clear write to address 1 with bit0 = 1 in the same cycle as a frame commit -> Get_Flag_o remains 1.
- With IR_CHECK_EN, frame 0x00000000 -> err set, no commit; without IR_CHECK_EN, it commits.
